// File: rtl/mprj_bram_arbiter_if.sv
// Bus bundle between the BRAM arbiter, the Wishbone slave decode, the FIR DMA
// and the BRAM macro. The slave modport is the arbiter's view.
interface mprj_bram_arbiter_if #(
    parameter int ADDR_W = 10
);
    // Handshakes: a Wishbone request is valid while cyc & stb & address-match and is
    // closed by a one-cycle wbs_ack_o. dma_req_i is a valid that holds its fields
    // stable until the one-cycle dma_gnt_o; a still-high dma_req_i in the cycle after
    // dma_gnt_o is a new request. dma_rvalid_o is a one-cycle data-valid with no
    // back-pressure. bram_en_o is a one-cycle access strobe with no back-pressure.
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [31:0]       wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;

    logic              dma_req_i;
    logic              dma_we_i;
    logic [ADDR_W-1:0] dma_addr_i;
    logic [31:0]       dma_wdata_i;
    logic              dma_gnt_o;
    logic              dma_rvalid_o;
    logic [31:0]       dma_rdata_o;

    logic              bram_en_o;
    logic [3:0]        bram_we_o;
    logic [ADDR_W-1:0] bram_addr_o;
    logic [31:0]       bram_wdata_o;
    logic [31:0]       bram_rdata_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
        output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
        output bram_en_o, bram_we_o, bram_addr_o, bram_wdata_o,
        input  bram_rdata_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
        input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
        input  bram_en_o, bram_we_o, bram_addr_o, bram_wdata_o,
        output bram_rdata_i
    );
endinterface

// File: rtl/mprj_bram_arbiter.sv
// Serialises Wishbone and FIR-DMA accesses onto the single-port user-project BRAM,
// waits out its fixed read latency and routes each response back to its owner.
module mprj_bram_arbiter #(
    parameter int         ADDR_W  = 10,
    parameter int         RD_LAT  = 10,
    parameter logic [7:0] BASE_HI = 8'h38
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    mprj_bram_arbiter_if.slave bus,
    output logic [1:0]         dbg_state,
    output logic               dbg_last_owner
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic       OWNER_CPU = 1'b0;
    localparam logic       OWNER_DMA = 1'b1;
    localparam logic [3:0] LAT_LAST  = 4'(RD_LAT - 1);

    state_t     state;
    logic       owner;
    logic       last_owner;
    logic       txn_we;
    logic       aborted;
    logic [3:0] lat_cnt;

    logic cpu_valid;
    logic cpu_wins;
    logic cpu_live;
    logic unused_adr_bits;

    assign cpu_valid = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:24] == BASE_HI);
    assign cpu_wins  = cpu_valid & (~bus.dma_req_i | (last_owner == OWNER_DMA));
    // A CPU response is only owed while the cycle has never been dropped.
    assign cpu_live  = (owner == OWNER_CPU) & ~aborted & bus.wbs_cyc_i;

    assign unused_adr_bits = ^{bus.wbs_adr_i[23:ADDR_W+2], bus.wbs_adr_i[1:0]};
    assign dbg_state       = state;
    assign dbg_last_owner  = last_owner;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state            <= IDLE;
            owner            <= OWNER_DMA;
            last_owner       <= OWNER_DMA;
            txn_we           <= 1'b0;
            aborted          <= 1'b0;
            lat_cnt          <= '0;
            bus.wbs_ack_o    <= 1'b0;
            bus.wbs_dat_o    <= '0;
            bus.dma_gnt_o    <= 1'b0;
            bus.dma_rvalid_o <= 1'b0;
            bus.dma_rdata_o  <= '0;
            bus.bram_en_o    <= 1'b0;
            bus.bram_we_o    <= '0;
            bus.bram_addr_o  <= '0;
            bus.bram_wdata_o <= '0;
        end else begin
            bus.bram_en_o    <= 1'b0;
            bus.bram_we_o    <= '0;
            bus.dma_gnt_o    <= 1'b0;
            bus.wbs_ack_o    <= 1'b0;
            bus.dma_rvalid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (cpu_valid | bus.dma_req_i) begin
                        state         <= ISSUE;
                        aborted       <= 1'b0;
                        bus.bram_en_o <= 1'b1;
                        if (cpu_wins) begin
                            owner            <= OWNER_CPU;
                            last_owner       <= OWNER_CPU;
                            txn_we           <= bus.wbs_we_i;
                            bus.bram_we_o    <= bus.wbs_we_i ? bus.wbs_sel_i : 4'h0;
                            bus.bram_addr_o  <= bus.wbs_adr_i[ADDR_W+1:2];
                            bus.bram_wdata_o <= bus.wbs_dat_i;
                        end else begin
                            owner            <= OWNER_DMA;
                            last_owner       <= OWNER_DMA;
                            txn_we           <= bus.dma_we_i;
                            bus.dma_gnt_o    <= 1'b1;
                            bus.bram_we_o    <= bus.dma_we_i ? 4'hF : 4'h0;
                            bus.bram_addr_o  <= bus.dma_addr_i;
                            bus.bram_wdata_o <= bus.dma_wdata_i;
                        end
                    end
                end

                ISSUE: begin
                    if ((owner == OWNER_CPU) && !bus.wbs_cyc_i) begin
                        aborted <= 1'b1;
                    end
                    if (txn_we) begin
                        state         <= RESP;
                        bus.wbs_ack_o <= cpu_live;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= LAT_LAST;
                    end
                end

                WAIT: begin
                    if ((owner == OWNER_CPU) && !bus.wbs_cyc_i) begin
                        aborted <= 1'b1;
                    end
                    // lat_cnt reaches zero exactly RD_LAT cycles after the ISSUE cycle.
                    if (lat_cnt == 4'd0) begin
                        state <= RESP;
                        if (owner == OWNER_CPU) begin
                            bus.wbs_dat_o <= bus.bram_rdata_i;
                            bus.wbs_ack_o <= cpu_live;
                        end else begin
                            bus.dma_rdata_o  <= bus.bram_rdata_i;
                            bus.dma_rvalid_o <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mprj_bram_arbiter.sv
// Bench for mprj_bram_arbiter: behavioural BRAM with fixed latency, Wishbone and DMA
// drivers, per-requester expected-response queues checked by a negedge monitor.
module tb_mprj_bram_arbiter;
    localparam int ADDR_W = 10;
    localparam int RD_LAT = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mprj_bram_arbiter_if #(.ADDR_W(ADDR_W)) bus();
    logic [1:0] dbg_state;
    logic       dbg_last_owner;

    mprj_bram_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .BASE_HI(8'h38)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .bus            (bus),
        .dbg_state      (dbg_state),
        .dbg_last_owner (dbg_last_owner)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic        pipe_v  [RD_LAT];
    logic [31:0] pipe_d  [RD_LAT];

    // bit 32 = response carries read data to compare
    logic [32:0] cpu_exp_q[$];
    logic [32:0] dma_exp_q[$];

    int   en_cyc_q[$];
    int   rv_cyc_q[$];
    int   last_en_cyc, last_ack_cyc, last_gnt_cyc;
    logic [3:0] last_en_we;
    int   ack_cnt = 0, gnt_cnt = 0, rv_cnt = 0, en_cnt = 0;
    logic prev_en = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Behavioural single-port BRAM: read data valid exactly RD_LAT cycles after the strobe.
    always @(posedge clk) begin
        if (bus.bram_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.bram_we_o[b]) mem[bus.bram_addr_o][8*b +: 8] <= bus.bram_wdata_o[8*b +: 8];
            end
        end
        pipe_v[0] <= bus.bram_en_o && (bus.bram_we_o == 4'h0);
        pipe_d[0] <= mem[bus.bram_addr_o];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign bus.bram_rdata_i = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (bus.bram_en_o) begin
                check("en_one_cycle", 32'(prev_en), 32'd0);
                en_cnt++;
                last_en_cyc = cyc_n;
                last_en_we  = bus.bram_we_o;
                en_cyc_q.push_back(cyc_n);
            end else if (bus.bram_we_o != 4'h0) begin
                check("we_outside_issue", 32'(bus.bram_we_o), 32'd0);
            end
            prev_en = bus.bram_en_o;
            if (bus.dma_gnt_o) begin
                gnt_cnt++;
                last_gnt_cyc = cyc_n;
            end
            if (bus.wbs_ack_o) begin
                ack_cnt++;
                last_ack_cyc = cyc_n;
                total++;
                if (cpu_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ack: ack at cycle %0d, none expected", cyc_n);
                end else begin
                    e = cpu_exp_q.pop_front();
                    if (e[32] && bus.wbs_dat_o !== e[31:0]) begin
                        bad++;
                        $display("FAIL cpu_rdata: got 0x%08h expected 0x%08h", bus.wbs_dat_o, e[31:0]);
                    end
                end
            end
            if (bus.dma_rvalid_o) begin
                rv_cnt++;
                rv_cyc_q.push_back(cyc_n);
                total++;
                if (dma_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rvalid: rvalid at cycle %0d, none expected", cyc_n);
                end else begin
                    e = dma_exp_q.pop_front();
                    if (bus.dma_rdata_o !== e[31:0]) begin
                        bad++;
                        $display("FAIL dma_rdata: got 0x%08h expected 0x%08h", bus.dma_rdata_o, e[31:0]);
                    end
                end
            end
        end
    end

    // Drivers
    task automatic cpu_issue(input logic we, input logic [3:0] sel, input logic [9:0] word,
                             input logic [31:0] data);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = {8'h38, 12'h000, word, 2'b00};
        bus.wbs_dat_i = data;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) ref_mem[word][8*b +: 8] = data[8*b +: 8];
            end
            cpu_exp_q.push_back({1'b0, 32'h0});
        end else begin
            cpu_exp_q.push_back({1'b1, ref_mem[word]});
        end
    endtask

    task automatic cpu_wait_ack();
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.wbs_ack_o && n < 500);
        if (!bus.wbs_ack_o) begin
            total++; bad++;
            $display("FAIL cpu_ack_timeout: no ack within %0d cycles", n);
        end
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [3:0] sel, input logic [9:0] word,
                              input logic [31:0] data, output int n_start);
        @(posedge clk); #1;
        n_start = cyc_n;
        cpu_issue(we, sel, word, data);
        cpu_wait_ack();
    endtask

    task automatic dma_issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        bus.dma_req_i   = 1'b1;
        bus.dma_we_i    = we;
        bus.dma_addr_i  = addr;
        bus.dma_wdata_i = data;
        if (we) ref_mem[addr] = data;
        else    dma_exp_q.push_back({1'b1, ref_mem[addr]});
    endtask

    task automatic dma_wait_gnt();
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.dma_gnt_o && n < 500);
        if (!bus.dma_gnt_o) begin
            total++; bad++;
            $display("FAIL dma_gnt_timeout: no grant within %0d cycles", n);
        end
    endtask

    task automatic dma_access(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        dma_issue(we, addr, data);
        dma_wait_gnt();
        @(posedge clk); #1;
        bus.dma_req_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(cpu_exp_q.size() == 0 && dma_exp_q.size() == 0 && dbg_state == 2'd0) && n < 2000) begin
            @(negedge clk); n++;
        end
        check("idle_reached", 32'(n < 2000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.dma_req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},    32'(bus.wbs_ack_o),    32'd0);
        check({tag, "_wdat"},   bus.wbs_dat_o,         32'd0);
        check({tag, "_gnt"},    32'(bus.dma_gnt_o),    32'd0);
        check({tag, "_rvalid"}, 32'(bus.dma_rvalid_o), 32'd0);
        check({tag, "_drdata"}, bus.dma_rdata_o,       32'd0);
        check({tag, "_en"},     32'(bus.bram_en_o),    32'd0);
        check({tag, "_we"},     32'(bus.bram_we_o),    32'd0);
        check({tag, "_addr"},   32'(bus.bram_addr_o),  32'd0);
        check({tag, "_bwdata"}, bus.bram_wdata_o,      32'd0);
        check({tag, "_state"},  32'(dbg_state),        32'd0);
        check({tag, "_owner"},  32'(dbg_last_owner),   32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, g0, r0, a0, e0;
        logic [31:0] v;

        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
        bus.dma_req_i = 1'b0; bus.dma_we_i = 1'b0; bus.dma_addr_i = '0; bus.dma_wdata_i = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            if (i == 16)      v = 32'hDEADBEEF;
            else if (i == 32) v = 32'h11223344;
            mem[i]     <= v;
            ref_mem[i]  = v;
        end
        for (int i = 0; i < RD_LAT; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_d[i] <= 32'h0;
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // CPU read of preloaded word 0x010
        g0 = gnt_cnt; r0 = rv_cnt;
        cpu_access(1'b0, 4'hF, 10'h010, 32'h0, n);
        check("rd_en_cycle",  32'(last_en_cyc),  32'(n + 1));
        check("rd_ack_cycle", 32'(last_ack_cyc), 32'(n + 2 + RD_LAT));
        check("rd_data",      bus.wbs_dat_o,     32'hDEADBEEF);
        check("rd_no_gnt",    32'(gnt_cnt),      32'(g0));
        check("rd_no_rvalid", 32'(rv_cnt),       32'(r0));

        // CPU byte write then read-back
        cpu_access(1'b1, 4'b0010, 10'h020, 32'h0000AB00, n);
        check("bw_we",        32'(last_en_we),   32'h2);
        check("bw_en_cycle",  32'(last_en_cyc),  32'(n + 1));
        check("bw_ack_cycle", 32'(last_ack_cyc), 32'(n + 2));
        cpu_access(1'b0, 4'hF, 10'h020, 32'h0, n);
        check("bw_readback",  bus.wbs_dat_o,     32'h1122AB44);

        // Address outside the BRAM window is ignored
        e0 = en_cnt;
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = 32'h3000_0040;
        repeat (20) @(posedge clk);
        #1 bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        check("off_window_no_en", 32'(en_cnt), 32'(e0));

        // Contention after reset: CPU first, then DMA
        do_reset();
        @(negedge clk);
        check("cont_owner_rst", 32'(dbg_last_owner), 32'd1);
        en_cyc_q.delete();
        @(posedge clk); #1;
        n = cyc_n;
        cpu_issue(1'b0, 4'hF, 10'h030, 32'h0);
        dma_issue(1'b0, 10'h040, 32'h0);
        fork
            cpu_wait_ack();
            begin dma_wait_gnt(); @(posedge clk); #1 bus.dma_req_i = 1'b0; end
        join
        wait_idle();
        check("cont1_cpu_en", 32'(en_cyc_q[0]), 32'(n + 1));
        check("cont1_dma_en", 32'(en_cyc_q[1]), 32'(n + RD_LAT + 4));
        check("cont1_dma_gnt", 32'(last_gnt_cyc), 32'(n + RD_LAT + 4));
        cpu_access(1'b1, 4'hF, 10'h031, 32'hCAFE0031, n2);
        check("cont_owner_cpu", 32'(dbg_last_owner), 32'd0);
        en_cyc_q.delete();
        @(posedge clk); #1;
        n = cyc_n;
        cpu_issue(1'b0, 4'hF, 10'h031, 32'h0);
        dma_issue(1'b0, 10'h041, 32'h0);
        fork
            cpu_wait_ack();
            begin dma_wait_gnt(); @(posedge clk); #1 bus.dma_req_i = 1'b0; end
        join
        wait_idle();
        check("cont2_dma_gnt", 32'(last_gnt_cyc), 32'(n + 1));
        check("cont2_cpu_en",  32'(en_cyc_q[1]),  32'(n + RD_LAT + 4));

        // DMA streaming: req held high across 8 reads
        rv_cyc_q.delete(); en_cyc_q.delete();
        g0 = gnt_cnt; r0 = rv_cnt;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            dma_issue(1'b0, 10'(i), 32'h0);
            dma_wait_gnt();
            @(posedge clk); #1;
        end
        bus.dma_req_i = 1'b0;
        wait_idle();
        check("stream_gnts",   32'(gnt_cnt - g0), 32'd8);
        check("stream_rvalid", 32'(rv_cnt - r0),  32'd8);
        for (int i = 1; i < 8 && i < en_cyc_q.size(); i++) begin
            check("stream_spacing", 32'(en_cyc_q[i] - en_cyc_q[i-1]), 32'(RD_LAT + 3));
        end

        // Wishbone abort with a DMA request pending
        a0 = ack_cnt;
        @(posedge clk); #1;
        n = cyc_n;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = {8'h38, 12'h000, 10'h050, 2'b00};
        while (cyc_n < n + 3) begin @(posedge clk); #1; end
        dma_issue(1'b0, 10'h210, 32'h0);
        while (cyc_n < n + 5) begin @(posedge clk); #1; end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        do @(negedge clk); while (cyc_n < n + 13);
        check("abort_idle", 32'(dbg_state), 32'd0);
        dma_wait_gnt();
        check("abort_dma_gnt", 32'(last_gnt_cyc), 32'(n + 14));
        @(posedge clk); #1 bus.dma_req_i = 1'b0;
        wait_idle();
        check("abort_no_ack", 32'(ack_cnt), 32'(a0));

        // Reset in the middle of a CPU read
        a0 = ack_cnt; r0 = rv_cnt;
        @(posedge clk); #1;
        n = cyc_n;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = {8'h38, 12'h000, 10'h060, 2'b00};
        while (cyc_n < n + 4) begin @(posedge clk); #1; end
        rst = 1'b1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        repeat (20) @(negedge clk);
        check("midrst_no_ack",    32'(ack_cnt),   32'(a0));
        check("midrst_no_rvalid", 32'(rv_cnt),    32'(r0));
        check("midrst_dat_clear", bus.wbs_dat_o,  32'd0);

        // Randomised concurrent traffic, disjoint regions per requester
        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    cpu_access(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                               10'(10'h100 + $urandom_range(0, 255)), $urandom, n2);
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    dma_access(1'($urandom_range(0, 1)), 10'(10'h200 + $urandom_range(0, 511)), $urandom);
                end
            end
        join
        wait_idle();
        check("rand_cpu_q_empty", 32'(cpu_exp_q.size()), 32'd0);
        check("rand_dma_q_empty", 32'(dma_exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
